// File: rtl/alu_sweep_pkg.sv
// ============================================================================
// Module   : alu_sweep_pkg
// Purpose  : Shared types and opcode constants for the ALU sweep collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_sweep_pkg;

    localparam int NUM_OPS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_0    = 4'h0;
    localparam logic [3:0] OP_1    = 4'h1;
    localparam logic [3:0] OP_2    = 4'h2;
    localparam logic [3:0] OP_3    = 4'h3;
    localparam logic [3:0] OP_4    = 4'h4;
    localparam logic [3:0] OP_5    = 4'h5;
    localparam logic [3:0] OP_6    = 4'h6;
    localparam logic [3:0] OP_7    = 4'h7;
    localparam logic [3:0] OP_8    = 4'h8;
    localparam logic [3:0] OP_9    = 4'h9;
    localparam logic [3:0] OP_LAST = OP_9;

endpackage

`default_nettype wire

// File: rtl/alu_sweep_collector_next_op_sel.sv
// ============================================================================
// Module   : next_op_sel
// Purpose  : Finds the next selected opcode strictly above idx (or the lowest
//            selected opcode when first is set).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_op_sel
    import alu_sweep_pkg::*;
(
    input  logic [NUM_OPS-1:0] mask,
    input  logic [3:0]         idx,
    input  logic               first,
    output logic [3:0]         next_idx,
    output logic               none_left
);

    // Scan downward so the lowest qualifying bit is the last one written.
    always_comb begin
        next_idx  = OP_0;
        none_left = 1'b1;
        for (int k = NUM_OPS - 1; k >= 0; k--) begin
            if (mask[k] && (first || (4'(k) > idx))) begin
                next_idx  = 4'(k);
                none_left = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_sweep_collector.sv
// ============================================================================
// Module   : alu_sweep_collector
// Purpose  : Sweeps ALUControl over a masked opcode subset and captures each
//            result/flags pair into a per-opcode readback bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sweep_collector
    import alu_sweep_pkg::*;
#(
    parameter int n = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_OPS-1:0] op_mask,
    input  logic [n-1:0]       alu_result,
    input  logic [3:0]         alu_flags,
    output logic [3:0]         ALUControl,
    output logic               busy,
    output logic               done,
    input  logic [3:0]         rd_sel,
    output logic [n-1:0]       rd_data,
    output logic [3:0]         rd_flags,
    output logic               rd_valid
);

    state_t               r_state;
    logic [NUM_OPS-1:0]   r_mask;
    logic [NUM_OPS-1:0]   r_valid;
    logic [n-1:0]         r_bank  [NUM_OPS];
    logic [3:0]           r_flags [NUM_OPS];

    logic [NUM_OPS-1:0]   w_sel_mask;
    logic                 w_first;
    logic [3:0]           w_next;
    logic                 w_none;

    // In IDLE the selector looks at the incoming mask to find the first opcode.
    assign w_first    = (r_state == IDLE);
    assign w_sel_mask = w_first ? op_mask : r_mask;

    next_op_sel u_next_op_sel (
        .mask      (w_sel_mask),
        .idx       (ALUControl),
        .first     (w_first),
        .next_idx  (w_next),
        .none_left (w_none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_valid    <= '0;
            ALUControl <= OP_0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int k = 0; k < NUM_OPS; k++) begin
                r_bank[k]  <= '0;
                r_flags[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_valid <= '0;
                        if (op_mask != '0) begin
                            r_mask     <= op_mask;
                            ALUControl <= w_next;
                            busy       <= 1'b1;
                            r_state    <= RUN;
                        end else begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                RUN: begin
                    // ALUControl doubles as the capture index while running.
                    r_bank[ALUControl]  <= alu_result;
                    r_flags[ALUControl] <= alu_flags;
                    r_valid[ALUControl] <= 1'b1;
                    if (w_none) begin
                        ALUControl <= OP_0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        ALUControl <= w_next;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    ALUControl <= OP_0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_flags = '0;
        rd_valid = 1'b0;
        if (rd_sel <= OP_LAST) begin
            rd_data  = r_bank[rd_sel];
            rd_flags = r_flags[rd_sel];
            rd_valid = r_valid[rd_sel];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_sweep_collector.sv
// ============================================================================
// Module   : tb_alu_sweep_collector
// Purpose  : Randomized self-checking bench for alu_sweep_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sweep_collector;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [9:0]   op_mask;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic [3:0]   ALUControl;
    logic         busy;
    logic         done;
    logic [3:0]   rd_sel;
    logic [N-1:0] rd_data;
    logic [3:0]   rd_flags;
    logic         rd_valid;

    // Behavioural ALU: a lookup table per opcode, reloaded per sweep.
    logic [N-1:0] res_tab [16];
    logic [3:0]   flg_tab [16];

    // Reference bank contents.
    logic [N-1:0] exp_data  [10];
    logic [3:0]   exp_flags [10];
    logic         exp_valid [10];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign alu_result = res_tab[ALUControl];
    assign alu_flags  = flg_tab[ALUControl];

    alu_sweep_collector #(.n(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_mask    (op_mask),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .ALUControl (ALUControl),
        .busy       (busy),
        .done       (done),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .rd_flags   (rd_flags),
        .rd_valid   (rd_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tables(input bit incr);
        for (int k = 0; k < 16; k++) begin
            res_tab[k] = incr ? N'(k + 1) : N'($urandom);
            flg_tab[k] = incr ? 4'h0 : 4'($urandom);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 10; k++) begin
            exp_data[k]  = '0;
            exp_flags[k] = '0;
            exp_valid[k] = 1'b0;
        end
    endtask

    task automatic check_bank(input string tag);
        for (int s = 0; s < 16; s++) begin
            rd_sel = 4'(s);
            #1;
            if (s < 10) begin
                chk({tag, "_data"},  32'(rd_data),  32'(exp_data[s]));
                chk({tag, "_flags"}, 32'(rd_flags), 32'(exp_flags[s]));
                chk({tag, "_valid"}, 32'(rd_valid), 32'(exp_valid[s]));
            end else begin
                chk({tag, "_hi_data"},  32'(rd_data),  32'h0);
                chk({tag, "_hi_flags"}, 32'(rd_flags), 32'h0);
                chk({tag, "_hi_valid"}, 32'(rd_valid), 32'h0);
            end
        end
    endtask

    // Runs one sweep from IDLE; poke_at >= 0 pulses start again mid-sweep.
    task automatic run_sweep(input logic [9:0] m, input int poke_at);
        int ops[$];
        for (int k = 0; k < 10; k++) if (m[k]) ops.push_back(k);
        start   = 1'b1;
        op_mask = m;
        tick();
        start   = 1'b0;
        op_mask = 10'h0;
        for (int i = 0; i < ops.size(); i++) begin
            chk("run_ctrl", 32'(ALUControl), 32'(ops[i]));
            chk("run_busy", 32'(busy), 32'h1);
            chk("run_done", 32'(done), 32'h0);
            if (i == poke_at) begin
                start   = 1'b1;
                op_mask = 10'h001;
            end
            tick();
            start   = 1'b0;
            op_mask = 10'h0;
        end
        chk("done_pulse", 32'(done), 32'h1);
        chk("done_busy",  32'(busy), 32'h0);
        chk("done_ctrl",  32'(ALUControl), 32'h0);
        tick();
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_ctrl", 32'(ALUControl), 32'h0);
        for (int k = 0; k < 10; k++) begin
            exp_valid[k] = m[k];
            if (m[k]) begin
                exp_data[k]  = res_tab[k];
                exp_flags[k] = flg_tab[k];
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_mask = 10'h0; rd_sel = 4'h0;
        load_tables(1'b1);
        model_clear();
        tick(); tick();
        rst = 1'b0;
        chk("rst_ctrl", 32'(ALUControl), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        check_bank("rst");

        run_sweep(10'h3FF, -1);
        check_bank("full");

        run_sweep(10'b10_0000_0101, -1);
        check_bank("sparse");

        run_sweep(10'h000, -1);
        check_bank("empty");

        run_sweep(10'h3FF, 3);
        check_bank("poke");

        // Reset after the third RUN cycle aborts without a done pulse.
        start = 1'b1; op_mask = 10'h3FF;
        tick();
        start = 1'b0; op_mask = 10'h0;
        tick(); tick(); tick();
        chk("pre_rst_ctrl", 32'(ALUControl), 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("abort_ctrl", 32'(ALUControl), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        tick();
        chk("abort_done2", 32'(done), 32'h0);
        check_bank("abort");
        run_sweep(10'h3FF, -1);
        check_bank("after_abort");

        // Back-to-back: a single-opcode sweep invalidates the rest.
        res_tab[0] = 4'hF;
        run_sweep(10'h001, -1);
        check_bank("b2b");

        for (int it = 0; it < 10; it++) begin
            load_tables(1'b0);
            run_sweep(10'($urandom_range(0, 1023)), int'($urandom_range(0, 12)) - 2);
            check_bank("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
